// File: rtl/taj_pkg.sv
// taj_pkg: FSM states, ring index helpers and the ring size bound for the TAJ ring controller.
package taj_pkg;
  localparam int TAJ_MAX_LEN = 16;
  typedef enum logic [2:0] {IDLE, CLEAR, PRIME_G, PRIME_P, ADV_G, ADV_P, DWELL_S, HALT} taj_state_t;
  function automatic logic [TAJ_MAX_LEN-1:0] onehot(input logic [3:0] idx);
    return TAJ_MAX_LEN'(1) << idx;
  endfunction
  function automatic logic [3:0] next_idx(input logic [3:0] idx, input int len);
    return (32'(idx) == len - 1) ? 4'd0 : idx + 4'd1;
  endfunction
endpackage

// File: rtl/taj_edge_det.sv
// taj_edge_det: registered rising-edge detector for a level input.
module taj_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);
  logic r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= 1'b0;
    else r_q <= i_d;
  assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/taj_ring_controller.sv
// taj_ring_controller: clears, primes and advances a ring of SMS_CARD_TAJ trigger cards.
// Define TAJ_RING_CHECK_EN to verify trig_b after every set pulse and halt on a ring fault.
module taj_ring_controller
  import taj_pkg::*;
#(
  parameter int RING_LEN = 10,
  parameter int PULSE_W  = 2,
  parameter int DWELL    = 3
) (
  input  logic                x,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                step_mode,
  input  logic                step,
  input  logic [RING_LEN-1:0] trig_b,
  output logic [RING_LEN-1:0] gate_l,
  output logic [RING_LEN-1:0] ac_set_l,
  output logic [RING_LEN-1:0] gate_r,
  output logic [RING_LEN-1:0] ac_set_r,
  output logic                rst_r_n,
  output logic [3:0]          pos,
  output logic                running,
  output logic                wrap,
  output logic                err
);
  localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] DW_CNT  = 4'(DWELL);
  taj_state_t          r_state;
  logic [3:0]          r_pos, r_cnt;
  logic [RING_LEN-1:0] r_gate_l, r_set_l, r_gate_r, r_set_r;
  logic                r_rst_r_n, r_wrap, r_chk, r_stop_req;
  logic                w_start_edge, w_step_edge, w_last, w_stop_now;
  logic [3:0]          w_nxt, w_nxt2;
  logic [RING_LEN-1:0] w_oh_pos, w_oh_nxt, w_oh_nxt2, w_oh_zero;
  taj_edge_det u_start_det (.clk(x), .rst(reset), .i_d(start), .o_rise(w_start_edge));
  taj_edge_det u_step_det  (.clk(x), .rst(reset), .i_d(step),  .o_rise(w_step_edge));
  assign w_nxt      = next_idx(r_pos, RING_LEN);
  assign w_nxt2     = next_idx(w_nxt, RING_LEN);
  assign w_oh_pos   = RING_LEN'(onehot(r_pos));
  assign w_oh_nxt   = RING_LEN'(onehot(w_nxt));
  assign w_oh_nxt2  = RING_LEN'(onehot(w_nxt2));
  assign w_oh_zero  = RING_LEN'(1);
  assign w_last     = 32'(r_pos) == RING_LEN - 1;
  assign w_stop_now = stop | r_stop_req;
  assign gate_l   = r_gate_l;
  assign ac_set_l = r_set_l;
  assign gate_r   = r_gate_r;
  assign ac_set_r = r_set_r;
  assign rst_r_n  = r_rst_r_n;
  assign pos      = r_pos;
  assign wrap     = r_wrap;
  assign running  = (r_state != IDLE) && (r_state != HALT);
`ifdef TAJ_RING_CHECK_EN
  logic r_err;
  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = ^{trig_b, r_chk};
  assign err = 1'b0;
`endif
  // Gates and sets are registered alongside the state so each one is glitch-free at the card.
  always_ff @(posedge x or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_pos      <= '0;
      r_cnt      <= '0;
      r_gate_l   <= '0;
      r_set_l    <= '0;
      r_gate_r   <= '0;
      r_set_r    <= '0;
      r_rst_r_n  <= 1'b1;
      r_wrap     <= 1'b0;
      r_chk      <= 1'b0;
      r_stop_req <= 1'b0;
`ifdef TAJ_RING_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_rst_r_n <= 1'b1;
      r_wrap    <= 1'b0;
      r_chk     <= 1'b0;
      case (r_state)
        IDLE, HALT:
          if (w_start_edge && (r_state == HALT || !stop)) begin
            r_state   <= CLEAR;
            r_rst_r_n <= 1'b0;
            r_pos     <= '0;
`ifdef TAJ_RING_CHECK_EN
            r_err     <= 1'b0;
`endif
          end
        CLEAR: begin
          r_state  <= PRIME_G;
          r_gate_r <= w_oh_zero;
        end
        PRIME_G: begin
          r_state <= PRIME_P;
          r_set_r <= r_gate_r;
          r_cnt   <= '0;
        end
        PRIME_P:
          if (r_cnt == PW_LAST) begin
            r_set_r <= '0;
            r_chk   <= 1'b1;
            r_cnt   <= 4'd1;
            if (DWELL == 0 && !stop && !step_mode) begin
              r_state  <= ADV_G;
              r_gate_l <= w_oh_pos;
              r_gate_r <= w_oh_nxt;
            end else begin
              r_state  <= DWELL_S;
              r_gate_r <= '0;
            end
          end else r_cnt <= r_cnt + 4'd1;
        ADV_G: begin
          r_state    <= ADV_P;
          r_set_l    <= r_gate_l;
          r_set_r    <= r_gate_r;
          r_cnt      <= '0;
          r_stop_req <= stop;
        end
        ADV_P:
          if (r_cnt == PW_LAST) begin
            r_pos      <= w_nxt;
            r_wrap     <= w_last;
            r_chk      <= 1'b1;
            r_cnt      <= 4'd1;
            r_stop_req <= 1'b0;
            r_set_l    <= '0;
            r_set_r    <= '0;
            if (!w_stop_now && DWELL == 0 && !step_mode) begin
              r_state  <= ADV_G;
              r_gate_l <= w_oh_nxt;
              r_gate_r <= w_oh_nxt2;
            end else begin
              r_state  <= w_stop_now ? IDLE : DWELL_S;
              r_gate_l <= '0;
              r_gate_r <= '0;
            end
          end else begin
            r_cnt      <= r_cnt + 4'd1;
            r_stop_req <= w_stop_now;
          end
        DWELL_S:
          if (r_cnt < DW_CNT) r_cnt <= r_cnt + 4'd1;
          else if (stop) r_state <= IDLE;
          else if (!step_mode || w_step_edge) begin
            r_state  <= ADV_G;
            r_gate_l <= w_oh_pos;
            r_gate_r <= w_oh_nxt;
          end
      endcase
`ifdef TAJ_RING_CHECK_EN
      if (r_chk && trig_b != w_oh_pos) begin
        r_state    <= HALT;
        r_err      <= 1'b1;
        r_gate_l   <= '0;
        r_set_l    <= '0;
        r_gate_r   <= '0;
        r_set_r    <= '0;
        r_cnt      <= '0;
        r_stop_req <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_taj_ring_controller.sv
// tb_taj_ring_controller: drives a modelled ring of 10 TAJ cards and checks the controller timeline.
module tb_taj_ring_controller;
  localparam int L  = 10;
  localparam int PW = 2;
  localparam int DW = 3;
  localparam int P  = 1 + PW + DW;
  logic x = 1'b0;
  logic reset, start, stop, step_mode, step;
  logic [L-1:0] trig_b, gate_l, ac_set_l, gate_r, ac_set_r;
  logic [L-1:0] cards = '0;
  logic [L-1:0] stuck;
  logic rst_r_n, running, wrap, err;
  logic [3:0] pos;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  taj_ring_controller #(.RING_LEN(L), .PULSE_W(PW), .DWELL(DW)) dut (
    .x(x), .reset(reset), .start(start), .stop(stop), .step_mode(step_mode), .step(step),
    .trig_b(trig_b), .gate_l(gate_l), .ac_set_l(ac_set_l), .gate_r(gate_r), .ac_set_r(ac_set_r),
    .rst_r_n(rst_r_n), .pos(pos), .running(running), .wrap(wrap), .err(err)
  );
  always #5 x = ~x;
  // Card plant: gated left set clears, gated right set sets, rst_r_n clears all.
  always @(posedge x)
    if (!rst_r_n) cards <= '0;
    else cards <= (cards & ~(gate_l & ac_set_l)) | (gate_r & ac_set_r);
  assign trig_b = cards & ~stuck;
  function automatic logic [L-1:0] oh(input int i);
    logic [L-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction
  function automatic bit at_adv_p(input int t, input int target);
    return t >= 2 + PW && ((t - 2 - PW) / P) % L == target && (t - 2 - PW) % P == DW + 1;
  endfunction
  task automatic tick();
    @(posedge x);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic check_idle(input logic [3:0] p);
    chk("idle_pos", 32'(pos), 32'(p));
    chk("idle_running", 32'(running), 32'(0));
    chk("idle_gates", 32'(gate_l | gate_r), 32'(0));
    chk("idle_sets", 32'(ac_set_l | ac_set_r), 32'(0));
    chk("idle_rst_r_n", 32'(rst_r_n), 32'(1));
    chk("idle_wrap", 32'(wrap), 32'(0));
  endtask
  // Expected outputs t clocks after the start edge in free run, from the advance schedule.
  task automatic check_at(input int t);
    logic [L-1:0] e_gl, e_sl, e_gr, e_sr;
    int k, ph, p;
    e_gl = '0; e_sl = '0; e_gr = '0; e_sr = '0;
    k = 0; ph = -1; p = 0;
    if (t == 1) e_gr = oh(0);
    else if (t >= 2 && t < 2 + PW) begin
      e_gr = oh(0);
      e_sr = oh(0);
    end else if (t >= 2 + PW) begin
      k = (t - 2 - PW) / P;
      ph = (t - 2 - PW) % P;
      p = k % L;
      if (ph >= DW) begin
        e_gl = oh(p);
        e_gr = oh((p + 1) % L);
      end
      if (ph > DW) begin
        e_sl = e_gl;
        e_sr = e_gr;
      end
    end
    chk("pos", 32'(pos), 32'(p));
    chk("gate_l", 32'(gate_l), 32'(e_gl));
    chk("gate_r", 32'(gate_r), 32'(e_gr));
    chk("ac_set_l", 32'(ac_set_l), 32'(e_sl));
    chk("ac_set_r", 32'(ac_set_r), 32'(e_sr));
    chk("rst_r_n", 32'(rst_r_n), 32'(t != 0));
    chk("running", 32'(running), 32'(1));
    chk("wrap", 32'(wrap), 32'(ph == 0 && k > 0 && p == 0));
    chk("err", 32'(err), 32'(0));
    if (ph == 0) chk("trig_b", 32'(trig_b), 32'(oh(p)));
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic stop_and_idle();
    stop = 1'b1;
    for (int g = 0; g < 3 * P && running; g++) tick();
    chk("stop_idle", 32'(running), 32'(0));
    stop = 1'b0;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int r, target;
    reset = 1'b1; start = 1'b0; stop = 1'b0; step_mode = 1'b0; step = 1'b0; stuck = '0;
    tick();
    tick();
    check_idle(4'd0);
    chk("rst_err", 32'(err), 32'(0));
    reset = 1'b0;
    tick();
    check_idle(4'd0);
    // free run over more than one wrap
    pulse_start();
    for (n = 0; n < 2 + PW + 12 * P; n++) begin
      check_at(n);
      tick();
    end
    for (int g = 0; g < 200 && !at_adv_p(n, 4); g++) begin
      check_at(n);
      tick();
      n++;
    end
    check_at(n);
    stop = 1'b1;
    tick();
    n++;
    check_at(n);
    stop = 1'b0;
    tick();
    check_idle(4'd5);
    r = $urandom_range(3, 12);
    repeat (r) tick();
    check_idle(4'd5);
    pulse_start();
    for (n = 0; n < 2 + PW + 2 * P; n++) begin
      check_at(n);
      tick();
    end
    stop_and_idle();
    stop = 1'b1;
    pulse_start();
    tick();
    chk("start_while_stop", 32'(running), 32'(0));
    stop = 1'b0;
    tick();
    // step mode: one advance per step edge only
    step_mode = 1'b1;
    pulse_start();
    for (n = 0; n < 2 + PW + DW; n++) begin
      check_at(n);
      tick();
    end
    r = $urandom_range(2, 15);
    repeat (r) tick();
    chk("step_wait_pos", 32'(pos), 32'(0));
    chk("step_wait_gate", 32'(gate_l | gate_r), 32'(0));
    chk("step_wait_run", 32'(running), 32'(1));
    for (int s = 1; s <= 3; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_gate_l", 32'(gate_l), 32'(oh(s - 1)));
      chk("step_gate_r", 32'(gate_r), 32'(oh(s)));
      chk("step_lead", 32'(ac_set_l | ac_set_r), 32'(0));
      repeat (PW + 1) tick();
      chk("step_pos", 32'(pos), 32'(s));
      chk("step_trig", 32'(trig_b), 32'(oh(s)));
      r = DW - 1 + $urandom_range(0, 6);
      repeat (r) tick();
      chk("step_hold", 32'(pos), 32'(s));
    end
    r = $urandom_range(4, 12);
    repeat (r) tick();
    chk("step_final", 32'(pos), 32'(3));
    stop_and_idle();
    step_mode = 1'b0;
    // reset in the middle of a set pulse
    target = $urandom_range(1, 3);
    pulse_start();
    n = 0;
    for (int g = 0; g < 200 && !at_adv_p(n, target); g++) begin
      check_at(n);
      tick();
      n++;
    end
    chk("pre_reset_set", 32'(ac_set_l), 32'(oh(target)));
    #2 reset = 1'b1;
    #1;
    check_idle(4'd0);
    tick();
    reset = 1'b0;
    tick();
    check_idle(4'd0);
    pulse_start();
    for (n = 0; n < 2 + PW + 2 * P; n++) begin
      check_at(n);
      tick();
    end
    stop_and_idle();
    // card 6 stuck at 0
    stuck = oh(6);
    pulse_start();
    for (n = 0; n < 2 + PW + 6 * P; n++) begin
      check_at(n);
      tick();
    end
    chk("stuck_pos", 32'(pos), 32'(6));
    chk("stuck_err_pre", 32'(err), 32'(0));
    tick();
`ifdef TAJ_RING_CHECK_EN
    chk("stuck_err", 32'(err), 32'(1));
    chk("stuck_halt", 32'(running), 32'(0));
    chk("stuck_gates", 32'(gate_l | gate_r | ac_set_l | ac_set_r), 32'(0));
    r = $urandom_range(2, 8);
    repeat (r) tick();
    chk("halt_hold", 32'(running), 32'(0));
    chk("halt_pos", 32'(pos), 32'(6));
    pulse_start();
    chk("halt_err_clr", 32'(err), 32'(0));
    chk("halt_clear", 32'(rst_r_n), 32'(0));
    chk("halt_restart", 32'(running), 32'(1));
    stuck = '0;
`else
    chk("stuck_err", 32'(err), 32'(0));
    chk("stuck_run", 32'(running), 32'(1));
    stuck = '0;
`endif
    stop_and_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
